// File: rtl/osd_uart_msg_gen_if.sv
// Character channel bundle between osd_uart_msg_gen and its osd_dem_uart sinks.
// A character moves on a rising clk edge where out_valid[c] & out_ready[c]; once
// out_valid[c] is high, out_valid[c] and out_char[8c+7:8c] hold until that edge.
interface osd_uart_msg_gen_if #(
  parameter int NUM_CH = 1
);
  logic [NUM_CH*8-1:0] out_char;
  logic [NUM_CH-1:0]   out_valid;
  logic [NUM_CH-1:0]   out_ready;

  modport master (output out_char, output out_valid, input out_ready);
  modport slave  (input out_char, input out_valid, output out_ready);
endinterface

// File: rtl/osd_uart_msg_gen.sv
// Plays a compile-time message on NUM_CH independent valid/ready character
// channels with one-shot/repeat playback, inter-message gap and start/stop control.
module osd_uart_msg_gen #(
  parameter int                   NUM_CH     = 1,
  parameter int                   MAX_LEN    = 16,
  parameter logic [MAX_LEN*8-1:0] MSG        = 128'h0000_000a_2164_6c72_6f57_206f_6c6c_6548,
  parameter int                   MSG_LEN    = 13,
  parameter int                   REPEAT     = 0,
  parameter int                   GAP        = 0,
  parameter int                   AUTO_START = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  osd_uart_msg_gen_if.master     ch_if,
  output logic [NUM_CH-1:0]      busy,
  output logic [NUM_CH-1:0]      done,
  output logic [NUM_CH*16-1:0]   sent_count,
  output logic [NUM_CH*2-1:0]    state_dbg_o
);

  localparam int               IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
  localparam logic [7:0]       GAP_V    = 8'(GAP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  logic [7:0] rom [MAX_LEN];

  for (genvar k = 0; k < MAX_LEN; k++) begin : g_rom
    assign rom[k] = MSG[8*k +: 8];
  end

  // auto_q is high exactly for the first cycle after rst drops.
  logic auto_q;
  logic start_go;

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_q <= (AUTO_START != 0);
    end else begin
      auto_q <= 1'b0;
    end
  end

  // stop beats start for every channel when both arrive together.
  assign start_go = (start | auto_q) & ~stop;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       gap_q, gap_d;
    logic             stop_pend_q, stop_pend_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             valid;
    logic             accept;

    assign valid  = (state_q == S_SEND);
    assign accept = valid & ch_if.out_ready[c];

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q     <= S_IDLE;
        idx_q       <= '0;
        gap_q       <= '0;
        stop_pend_q <= 1'b0;
        cnt_q       <= '0;
      end else begin
        state_q     <= state_d;
        idx_q       <= idx_d;
        gap_q       <= gap_d;
        stop_pend_q <= stop_pend_d;
        cnt_q       <= cnt_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      gap_d       = gap_q;
      stop_pend_d = stop_pend_q;
      cnt_d       = cnt_q;

      if (accept && (cnt_q != 16'hFFFF)) begin
        cnt_d = cnt_q + 16'd1;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_go) begin
            state_d     = S_SEND;
            idx_d       = '0;
            stop_pend_d = 1'b0;
          end
        end
        S_SEND: begin
          if (accept) begin
            if (stop || stop_pend_q) begin
              // a requested stop waits for the pending character to be taken
              state_d     = S_IDLE;
              idx_d       = '0;
              stop_pend_d = 1'b0;
            end else if (idx_q == LAST_IDX) begin
              idx_d = '0;
              if (REPEAT == 0) begin
                state_d = S_DONE;
              end else if (GAP_V != 8'd0) begin
                state_d = S_GAP;
                gap_d   = GAP_V;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (stop) begin
            stop_pend_d = 1'b1;
          end
        end
        S_GAP: begin
          if (stop) begin
            state_d = S_IDLE;
            gap_d   = '0;
          end else if (gap_q == 8'd1) begin
            state_d = S_SEND;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    assign ch_if.out_valid[c]       = valid;
    assign ch_if.out_char[8*c +: 8] = valid ? rom[idx_q] : 8'h00;
    assign busy[c]                  = (state_q == S_SEND) || (state_q == S_GAP);
    assign done[c]                  = (state_q == S_DONE);
    assign sent_count[16*c +: 16]   = cnt_q;
    assign state_dbg_o[2*c +: 2]    = state_q;
  end

endmodule

// File: tb/tb_osd_uart_msg_gen.sv
// Bench for osd_uart_msg_gen: three instances (two-channel one-shot, repeat with
// gap, back-to-back repeat) checked by an expected-byte scoreboard per channel.
module tb_osd_uart_msg_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic start_a = 1'b0, stop_a = 1'b0;
  logic start_b = 1'b0, stop_b = 1'b0;
  logic start_c = 1'b0, stop_c = 1'b0;

  logic [1:0]  busy_a, done_a;
  logic [31:0] sent_a;
  logic [3:0]  dbg_a;
  logic        busy_b, done_b, busy_c, done_c;
  logic [15:0] sent_b, sent_c;
  logic [1:0]  dbg_b, dbg_c;

  osd_uart_msg_gen_if #(.NUM_CH(2)) if_a ();
  osd_uart_msg_gen_if #(.NUM_CH(1)) if_b ();
  osd_uart_msg_gen_if #(.NUM_CH(1)) if_c ();

  osd_uart_msg_gen #(.NUM_CH(2)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .stop(stop_a), .ch_if(if_a),
    .busy(busy_a), .done(done_a), .sent_count(sent_a), .state_dbg_o(dbg_a)
  );

  osd_uart_msg_gen #(.NUM_CH(1), .REPEAT(1), .GAP(3), .AUTO_START(0)) u_b (
    .clk(clk), .rst(rst_b), .start(start_b), .stop(stop_b), .ch_if(if_b),
    .busy(busy_b), .done(done_b), .sent_count(sent_b), .state_dbg_o(dbg_b)
  );

  osd_uart_msg_gen #(.NUM_CH(1), .REPEAT(1), .GAP(0), .AUTO_START(0)) u_c (
    .clk(clk), .rst(rst_c), .start(start_c), .stop(stop_c), .ch_if(if_c),
    .busy(busy_c), .done(done_c), .sent_count(sent_c), .state_dbg_o(dbg_c)
  );

  // ---------------- scoreboard state ----------------
  string      msg_s = "Hello World!\n";
  logic [7:0] exp_q0[$], exp_q1[$], exp_q2[$], exp_q3[$];
  logic       hold [4];
  logic [7:0] held [4];
  int         tests_run = 0;
  int         tests_failed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int q_size(input int ch);
    case (ch)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return exp_q2.size();
      default: return exp_q3.size();
    endcase
  endfunction

  task automatic q_push(input int ch, input logic [7:0] b);
    case (ch)
      0: exp_q0.push_back(b);
      1: exp_q1.push_back(b);
      2: exp_q2.push_back(b);
      default: exp_q3.push_back(b);
    endcase
  endtask

  task automatic q_pop(input int ch, output logic [7:0] b);
    case (ch)
      0: b = exp_q0.pop_front();
      1: b = exp_q1.pop_front();
      2: b = exp_q2.pop_front();
      default: b = exp_q3.pop_front();
    endcase
  endtask

  task automatic q_clear(input int ch);
    case (ch)
      0: exp_q0.delete();
      1: exp_q1.delete();
      2: exp_q2.delete();
      default: exp_q3.delete();
    endcase
  endtask

  // reference model: one playback of the message is its bytes in string order
  task automatic push_msg(input int ch);
    for (int k = 0; k < msg_s.len(); k++) q_push(ch, msg_s[k]);
  endtask

  // ---------------- monitor ----------------
  task automatic mon_step(input int ch, input logic rs, input logic v, input logic r,
                          input logic [7:0] c);
    logic [7:0] e;
    if (rs) begin
      hold[ch] = 1'b0;
    end else begin
      if (hold[ch]) begin
        check($sformatf("ch%0d_hold_valid", ch), 32'(v), 32'd1);
        check($sformatf("ch%0d_hold_char", ch), 32'(c), 32'(held[ch]));
      end
      if (!v) check($sformatf("ch%0d_idle_char", ch), 32'(c), 32'd0);
      if (v && r) begin
        if (q_size(ch) == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL ch%0d_extra: got 0x%0h expected no character", ch, c);
        end else begin
          q_pop(ch, e);
          check($sformatf("ch%0d_data", ch), 32'(c), 32'(e));
        end
      end
      hold[ch] = v && !r;
      held[ch] = c;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      hold[i] = 1'b0;
      held[i] = 8'h00;
    end
    forever begin
      @(negedge clk);
      mon_step(0, rst_a, if_a.out_valid[0], if_a.out_ready[0], if_a.out_char[7:0]);
      mon_step(1, rst_a, if_a.out_valid[1], if_a.out_ready[1], if_a.out_char[15:8]);
      mon_step(2, rst_b, if_b.out_valid[0], if_b.out_ready[0], if_b.out_char[7:0]);
      mon_step(3, rst_c, if_c.out_valid[0], if_c.out_ready[0], if_c.out_char[7:0]);
    end
  end

  // ---------------- ready driver ----------------
  // mode: 0 always ready, 1 random ~70% ready, 2 every 4th cycle, 3 manual
  int          mode [4] = '{0, 2, 0, 0};
  logic        man [4]  = '{1'b0, 1'b0, 1'b0, 1'b0};
  int unsigned cyc = 0;

  function automatic logic pick_ready(input int ch);
    case (mode[ch])
      0: return 1'b1;
      1: return ($urandom_range(0, 9) >= 3);
      2: return ((cyc % 4) == 0);
      default: return man[ch];
    endcase
  endfunction

  initial begin
    logic r [4];
    if_a.out_ready = 2'b11;
    if_b.out_ready = 1'b1;
    if_c.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      for (int ch = 0; ch < 4; ch++) r[ch] = pick_ready(ch);
      if_a.out_ready = {r[1], r[0]};
      if_b.out_ready = r[2];
      if_c.out_ready = r[3];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic sa, input logic pa, input logic sb, input logic pb,
                       input logic sc, input logic pc);
    @(posedge clk); #1;
    start_a = sa; stop_a = pa; start_b = sb; stop_b = pb; start_c = sc; stop_c = pc;
    @(posedge clk); #1;
    start_a = 0; stop_a = 0; start_b = 0; stop_b = 0; start_c = 0; stop_c = 0;
  endtask

  // wait (bounded) for the negedge where a channel of b/c presents 0x0a and it is taken
  task automatic wait_last(input int ch, output logic found);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ch == 2 && if_b.out_valid[0] && if_b.out_ready[0] && if_b.out_char == 8'h0a) begin
        found = 1'b1;
        break;
      end
      if (ch == 3 && if_c.out_valid[0] && if_c.out_ready[0] && if_c.out_char == 8'h0a) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int   n, nv, n1, gap;
    logic found;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_rst_valid", 32'(if_a.out_valid), 32'd0);
    check("a_rst_char", 32'(if_a.out_char), 32'd0);
    check("a_rst_busy", 32'(busy_a), 32'd0);
    check("a_rst_done", 32'(done_a), 32'd0);
    check("a_rst_sent", sent_a, 32'd0);
    check("b_rst_valid", 32'(if_b.out_valid), 32'd0);
    check("c_rst_sent", 32'(sent_c), 32'd0);

    // auto start: ch0 always ready, ch1 ready every 4th cycle
    push_msg(0);
    push_msg(1);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    check("a_auto_idle_cycle", 32'(if_a.out_valid), 32'd0);
    @(negedge clk);
    check("a_auto_valid", 32'(if_a.out_valid), 32'd3);
    nv = 1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done_a[0]) break;
      if (if_a.out_valid[0]) nv++;
    end
    check("a0_done", 32'(done_a[0]), 32'd1);
    check("a0_valid_cycles", 32'(nv), 32'd13);
    check("a0_done_cycle", 32'(n), 32'd13);
    check("a0_valid_after", 32'(if_a.out_valid[0]), 32'd0);
    check("a0_busy_after", 32'(busy_a[0]), 32'd0);
    check("a0_sent", 32'(sent_a[15:0]), 32'd13);
    while (n < 300 && !done_a[1]) begin
      @(negedge clk);
      n++;
    end
    n1 = n;
    check("a1_done", 32'(done_a[1]), 32'd1);
    check("a1_done_window", 32'(n1 >= 44 && n1 <= 58), 32'd1);
    check("a1_busy_after", 32'(busy_a[1]), 32'd0);
    check("a1_sent", 32'(sent_a[31:16]), 32'd13);
    check("a_queues_drained", 32'(q_size(0) + q_size(1)), 32'd0);

    // restart from DONE, ignored start while busy, stop with ch1 backpressured
    mode[0] = 0;
    mode[1] = 3;
    man[1]  = 1'b0;
    push_msg(0);
    push_msg(1);
    pulse(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("a_restart_valid", 32'(if_a.out_valid), 32'd3);
    check("a_restart_done_clr", 32'(done_a), 32'd0);
    pulse(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("a_start_busy_ignored", 32'(busy_a), 32'd3);
    n = 0;
    while (n < 100 && !done_a[0]) begin
      @(negedge clk);
      n++;
    end
    check("a0_done_2", 32'(done_a[0]), 32'd1);
    @(posedge clk); #1;
    man[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    man[1] = 1'b0;
    @(negedge clk);
    check("a1_byte5_char", 32'(if_a.out_char[15:8]), 32'h20);
    pulse(0, 1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("a1_stop_hold_valid", 32'(if_a.out_valid[1]), 32'd1);
    check("a1_stop_hold_char", 32'(if_a.out_char[15:8]), 32'h20);
    check("a1_stop_hold_busy", 32'(busy_a[1]), 32'd1);
    @(posedge clk); #1;
    man[1] = 1'b1;
    @(posedge clk); #1;
    man[1] = 1'b0;
    @(negedge clk);
    check("a1_stop_idle_valid", 32'(if_a.out_valid[1]), 32'd0);
    check("a1_stop_idle_busy", 32'(busy_a[1]), 32'd0);
    check("a1_stop_no_done", 32'(done_a[1]), 32'd0);
    check("a1_stop_remaining", 32'(q_size(1)), 32'd7);
    q_clear(1);
    check("a_sent_after_stop", sent_a, {16'd19, 16'd26});

    // start and stop together: nothing starts
    pulse(1, 1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("a_startstop_valid", 32'(if_a.out_valid), 32'd0);
    check("a_startstop_busy", 32'(busy_a), 32'd0);
    check("a_startstop_done", 32'(done_a), 32'd1);

    // random backpressure, rst while ch0 is on byte 7
    mode[0] = 1;
    mode[1] = 1;
    push_msg(0);
    push_msg(1);
    pulse(1, 0, 0, 0, 0, 0);
    n = 0;
    while (q_size(0) > 6 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("a_reach_byte7", 32'(q_size(0)), 32'd6);
    rst_a = 1'b1;
    @(posedge clk); #1;
    q_clear(0);
    q_clear(1);
    push_msg(0);
    push_msg(1);
    @(negedge clk);
    check("a_midrst_sent", sent_a, 32'd0);
    check("a_midrst_valid", 32'(if_a.out_valid), 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("a_restart_char0", 32'(if_a.out_char[7:0]), 32'h48);
    check("a_restart_char1", 32'(if_a.out_char[15:8]), 32'h48);
    n = 0;
    while (n < 400 && done_a != 2'b11) begin
      @(negedge clk);
      n++;
    end
    check("a_random_done", 32'(done_a), 32'd3);
    check("a_random_sent", sent_a, {16'd13, 16'd13});
    check("a_random_drained", 32'(q_size(0) + q_size(1)), 32'd0);

    // repeat with GAP=3
    @(negedge clk);
    check("b_no_auto_start", 32'(if_b.out_valid), 32'd0);
    mode[2] = 0;
    push_msg(2);
    push_msg(2);
    push_msg(2);
    pulse(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("b_start_valid", 32'(if_b.out_valid), 32'd1);
    wait_last(2, found);
    check("b_last_seen_1", 32'(found), 32'd1);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_b.out_valid[0]) break;
      gap++;
    end
    check("b_gap_len", 32'(gap), 32'd3);
    check("b_after_gap_char", 32'(if_b.out_char), 32'h48);
    wait_last(2, found);
    check("b_last_seen_2", 32'(found), 32'd1);
    pulse(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("b_stop_gap_busy", 32'(busy_b), 32'd0);
    check("b_stop_gap_done", 32'(done_b), 32'd0);
    repeat (4) @(negedge clk);
    check("b_stop_gap_stays", 32'(if_b.out_valid), 32'd0);
    check("b_remaining", 32'(q_size(2)), 32'd13);
    q_clear(2);
    check("b_sent", 32'(sent_b), 32'd26);

    // repeat with GAP=0, then saturation of sent_count
    mode[3] = 0;
    push_msg(3);
    push_msg(3);
    pulse(0, 0, 0, 0, 1, 0);
    wait_last(3, found);
    check("c_last_seen", 32'(found), 32'd1);
    @(negedge clk);
    check("c_b2b_valid", 32'(if_c.out_valid), 32'd1);
    check("c_b2b_char", 32'(if_c.out_char), 32'h48);
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk); #1;
      if (q_size(3) < 13) push_msg(3);
    end
    @(negedge clk);
    check("c_sent_saturated", 32'(sent_c), 32'h0000FFFF);
    check("c_still_flowing", 32'(if_c.out_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
